// File: rtl/pal_cfg_loader.sv
// pal_cfg_loader: upstream configuration stage for the PAL array.
// Takes W-bit words from a host over valid/ready and shifts exactly
// SR_LEN = 2*N*P + P*M bits, MSB first, onto the PAL serial config chain
// using a self-generated shift clock (2 CLK per bit).
//
// Handshake: a word transfers on a rising CLK edge where WORD_VALID and
// WORD_READY are both 1; WORD_READY depends only on state (high in LOAD),
// never on WORD_VALID, and WORD_VALID outside LOAD is ignored.
//
// Optional feature: define CFG_CRC_EN to build a bit-serial CRC-8
// (poly 0x07, init 0x00) over the shifted stream; otherwise CRC_OUT is 0.
//
// DBG_STATE exposes the FSM state for debug/checker binding.
module pal_cfg_loader #(
    parameter int N = 8,
    parameter int M = 8,
    parameter int P = 8,
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         START,
    input  logic [W-1:0] WORD_IN,
    input  logic         WORD_VALID,
    output logic         WORD_READY,
    output logic         BUSY,
    output logic         DONE,
    output logic         CFG_SCLK,
    output logic         CFG_DATA,
    output logic [7:0]   CRC_OUT,
    output logic [2:0]   DBG_STATE
);

    localparam int SR_LEN = 2*N*P + P*M;
    localparam int CW     = $clog2(SR_LEN + 1);
    localparam int BW     = $clog2(W + 1);

    localparam logic [CW-1:0] SR_LEN_C = CW'(SR_LEN);
    localparam logic [BW-1:0] W_C      = BW'(W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SH_LO = 3'd2,
        S_SH_HI = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_cfg_sclk;
    logic          r_cfg_data;
    logic [W-1:0]  r_word;
    logic [CW-1:0] r_bit_cnt;
    logic [BW-1:0] r_bit_in_word;
    logic [W-1:0]  w_word_shl;

    // Word register shifted by one; its MSB is the next bit to present.
    assign w_word_shl = r_word << 1;

    // Main load sequencer. The bit counters advance on entry to SH_HI so
    // that the exit decision in SH_HI sees the count including the bit
    // the PAL is sampling in that cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cfg_sclk    <= 1'b0;
            r_cfg_data    <= 1'b0;
            r_word        <= '0;
            r_bit_cnt     <= '0;
            r_bit_in_word <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_state   <= S_LOAD;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_bit_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (WORD_VALID) begin
                        r_word        <= WORD_IN;
                        r_cfg_data    <= WORD_IN[W-1];
                        r_bit_in_word <= '0;
                        r_state       <= S_SH_LO;
                    end
                end
                S_SH_LO: begin
                    r_cfg_sclk    <= 1'b1;
                    r_bit_cnt     <= r_bit_cnt + CW'(1);
                    r_bit_in_word <= r_bit_in_word + BW'(1);
                    r_state       <= S_SH_HI;
                end
                S_SH_HI: begin
                    r_cfg_sclk <= 1'b0;
                    if (r_bit_cnt == SR_LEN_C) begin
                        // Whole chain shifted; any leftover low bits of
                        // the final word are simply dropped.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (r_bit_in_word == W_C) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_word     <= w_word_shl;
                        r_cfg_data <= w_word_shl[W-1];
                        r_state    <= S_SH_LO;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CFG_CRC_EN
    logic [7:0] r_crc;
    logic       w_crc_fb;
    logic [7:0] w_crc_next;

    assign w_crc_fb   = r_crc[7] ^ r_cfg_data;
    assign w_crc_next = {r_crc[6:0], 1'b0} ^ (w_crc_fb ? 8'h07 : 8'h00);

    // CRC absorbs the presented bit on the same edge the PAL sees SCLK rise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_crc <= 8'h00;
        end else if ((r_state == S_IDLE) && START) begin
            r_crc <= 8'h00;
        end else if (r_state == S_SH_LO) begin
            r_crc <= w_crc_next;
        end
    end

    assign CRC_OUT = r_crc;
`else
    assign CRC_OUT = 8'h00;
`endif

    assign WORD_READY = (r_state == S_LOAD);
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign CFG_SCLK   = r_cfg_sclk;
    assign CFG_DATA   = r_cfg_data;
    assign DBG_STATE  = r_state;

endmodule

// File: doc/pal_cfg_loader.md
Name: pal_cfg_loader

Overview:
- Upstream configuration stage for the PAL array.
- Accepts W-bit configuration words from a host over a valid/ready handshake and serialises them onto the PAL's serial configuration input.
- Generates its own configuration shift clock and shifts out exactly SR_LEN = 2*N*P + P*M bits.
- Reports BUSY while loading and DONE once the array is fully configured.

Parameters:
- N, 8, PAL input count.
- M, 8, PAL output count.
- P, 8, PAL product-term count.
- W, 8, host word width in bits; legal range 1..32.
- SR_LEN (local, derived): 2*N*P + P*M; 192 at defaults.
- NWORDS (local, derived): ceil(SR_LEN/W); 24 at defaults.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begin a load; sampled only in IDLE.
- WORD_IN  in  W  configuration word; its MSB is shifted first.
- WORD_VALID  in  1  WORD_IN is valid.
- WORD_READY  out  1  loader accepts a word this cycle.
- BUSY  out  1  load in progress.
- DONE  out  1  last load completed; sticky.
- CFG_SCLK  out  1  shift clock to the PAL configuration chain; idles low.
- CFG_DATA  out  1  serial configuration bit to the PAL CFG input.
- CRC_OUT  out  8  stream CRC (see Optional Feature).

Behaviour:
- All outputs are registered, except WORD_READY, which is decoded from state: WORD_READY = (state == LOAD).
- Reset (any state, including mid-load): state IDLE, BUSY 0, DONE 0, CFG_SCLK 0, CFG_DATA 0, CRC_OUT 0, all counters 0. The PAL then holds a partial configuration and the host must reload it.
- IDLE:
  - START=1 → go to LOAD; BUSY←1; DONE←0; bit_cnt←0.
- LOAD:
  - WORD_READY=1.
  - On WORD_VALID & WORD_READY: capture WORD_IN into the word shift register; CFG_DATA←WORD_IN[W-1]; bit_in_word←0; go to SH_LO.
  - With no handshake, stay in LOAD; CFG_SCLK stays 0 and CFG_DATA holds.
- SH_LO (one cycle):
  - CFG_SCLK=0, CFG_DATA stable; next state SH_HI.
- SH_HI (one cycle):
  - CFG_SCLK←1, so the PAL samples CFG_DATA on this rising edge.
  - bit_cnt++, bit_in_word++.
  - On exit, CFG_SCLK←0 and the next state is chosen as follows:
    - bit_cnt == SR_LEN → DONE_ST; BUSY←0; DONE←1.
    - else if bit_in_word == W → LOAD.
    - else → shift the word register left, CFG_DATA←next bit, go to SH_LO.
- DONE_ST:
  - Returns to IDLE the next cycle. DONE stays 1 until the next accepted START or a reset.
- Bit ordering:
  - Stream bit 0 is the first shifted and ends at PAL chain MSB (the OR plane top).
  - Word k supplies stream bits k*W .. k*W+W-1, MSB first.
  - In the final word, only the top (SR_LEN - (NWORDS-1)*W) bits are shifted; the remaining low bits are discarded.
- Timing:
  - Each bit takes 2 CLK; data is stable one full CLK before and during the CFG_SCLK high cycle.
  - Each word costs 1 LOAD cycle plus 2W shift cycles.
  - Exactly SR_LEN CFG_SCLK rising edges per load, never more.
- START while BUSY is ignored.
- WORD_VALID outside LOAD is ignored; no word is consumed.
- bit_cnt width is clog2(SR_LEN+1); it never wraps within a load.

Optional Feature:
- CFG_CRC_EN defined:
  - CRC-8, polynomial 0x07, init 0x00, non-reflected, updated bit-serially on each SH_HI with the shifted bit: fb = crc[7]^bit; crc = (crc<<1) ^ (fb ? 0x07 : 0).
  - Cleared on accepted START.
  - CRC_OUT is valid while DONE=1.
- CFG_CRC_EN undefined:
  - No CRC logic; CRC_OUT tied to 8'h00.

Test Plan:
1. Assert RST for 2 cycles during the SH_HI of bit 10 → next cycle BUSY=0, DONE=0, CFG_SCLK=0, CFG_DATA=0, WORD_READY=0, CRC_OUT=0.
2. Defaults, START then 24 words of 0xFF with WORD_VALID held high → exactly 192 CFG_SCLK rising edges, each with CFG_DATA=1; DONE rises 408 CLK after START is sampled; BUSY falls in the same cycle.
3. N=M=P=1, W=8, START, one word 0xA0 → exactly 3 CFG_SCLK edges, sampling CFG_DATA 1,0,1; DONE=1; with CFG_CRC_EN, CRC_OUT=0x1B.
4. Defaults, WORD_VALID dropped for 5 cycles between words 3 and 4 → WORD_READY stays 1 and CFG_SCLK stays 0 throughout the gap; CFG_DATA holds its last value; total edge count remains 192.
5. Pulse START again mid-load → ignored, bit_cnt unaffected. After 50 bits, assert RST, then START and 24 words → 192 fresh edges and DONE=1.
6. Defaults, W=5 (NWORDS=39), last word 0b11111 → only the top 2 bits are shifted; edge count 192; the third CFG_DATA-high bit of that word never appears.
